// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a
// two-entry {instr, pc} buffer, with redirect flush and stale-response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid
);

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [1:0] BufFull = BUF_DEPTH[1:0];

    state_t      state_q, state_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
    logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;

    logic        ackValid;
    logic        pop;
    logic        push;
    logic [1:0]  wrIdx;
    logic [31:0] redirectTarget;

    assign redirectTarget = RedirectPC & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            fetchPc_q <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            count_q   <= 2'd0;
            instr0_q  <= 32'd0;
            pc0_q     <= 32'd0;
            instr1_q  <= 32'd0;
            pc1_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            count_q   <= count_d;
            instr0_q  <= instr0_d;
            pc0_q     <= pc0_d;
            instr1_q  <= instr1_d;
            pc1_q     <= pc1_d;
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down before the push lands.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        instr0_d  = instr0_q;
        pc0_d     = pc0_q;
        instr1_d  = instr1_q;
        pc1_d     = pc1_q;

        ackValid = IMem_Ack & req_q;
        pop      = (count_q != 2'd0) & ~Stall & ~Redirect;
        push     = ackValid & (state_q == FETCH) & ~Redirect;
        wrIdx    = count_q - {1'b0, pop};
        count_d  = wrIdx + {1'b0, push};

        if (pop) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
        end
        if (push) begin
            fetchPc_d = fetchPc_q + 32'd4;
            if (wrIdx == 2'd0) begin
                instr0_d = IMem_Data;
                pc0_d    = addr_q;
            end else begin
                instr1_d = IMem_Data;
                pc1_d    = addr_q;
            end
        end
        if (Redirect) begin
            count_d   = 2'd0;
            fetchPc_d = redirectTarget;
        end

        // A pending request is held until acked; a redirect turns it stale.
        if (req_q && !ackValid) begin
            if (Redirect) begin
                state_d = DISCARD;
            end
        end else if (state_q == DISCARD) begin
            state_d = FETCH;
            req_d   = 1'b0;
        end else if (count_d < BufFull) begin
            req_d  = 1'b1;
            addr_d = fetchPc_d;
        end else begin
            req_d = 1'b0;
        end
    end

    assign IMem_Req   = req_q;
    assign IMem_Addr  = addr_q;
    assign Instr      = instr0_q;
    assign InstrPC    = pc0_q;
    assign InstrValid = (count_q != 2'd0);

endmodule
